jtag_dump_reader: RTL and testbench

//  Downstream consumer of the JTAG capture engine. Holds the 512x32 capture RAM
//  (TDI words at 0x000.., TDO words at TDO_BASE..) fed by the engine's ram_we/waddr/wdata.
//  On a rising edge of the engine's INT it reads back ceil(DATALEN/32) TDI words,

---
 rtl/jtag_dump_reader.sv | 129 ++++++++++++
 tb/tb_jtag_dump_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dump_reader.sv
// Capture RAM plus read-back sequencer: on a rising INT, streams the TDI words and then
// the TDO words of the last capture to the host, then pulses clear_int_o to re-arm the engine.
module jtag_dump_reader #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int TDO_BASE  = 'h80,
  parameter int MAX_WORDS = 128
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_waddr,
  input  logic [DATA_W-1:0] ram_wdata,
  input  logic              int_i,
  input  logic [15:0]       datalen_i,
  output logic              clear_int_o,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sel,
  output logic              m_last,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int          IDX_W = $clog2(MAX_WORDS);
  localparam logic [10:0] MAX_N = 11'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, CALC, READ, WAIT, SEND, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] raddr;
  logic              int_q;
  logic              sel;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [10:0]       n_raw;
  logic              unused_datalen_msb;

  // Word count rounds a partial trailing dword up to a whole word.
  assign n_raw = {1'b0, datalen_i[14:5]} + {10'd0, |datalen_i[4:0]};
  assign raddr = (sel ? ADDR_W'(TDO_BASE) : '0) + ADDR_W'(idx);
  assign unused_datalen_msb = datalen_i[15];

  // Unreset storage: non-blocking read gives old data on a same-address collision.
  always_ff @(posedge sclk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rdata <= mem[raddr];
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      int_q       <= 1'b0;
      sel         <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      clear_int_o <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sel       <= 1'b0;
      m_last      <= 1'b0;
      busy_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      int_q <= int_i;
      case (state)
        IDLE: begin
          if (int_i && !int_q) begin
            state  <= CALC;
            busy_o <= 1'b1;
          end
        end
        CALC: begin
          sel <= 1'b0;
          idx <= '0;
          if (n_raw > MAX_N) begin
            last_idx   <= IDX_W'(MAX_N - 11'd1);
            overflow_o <= 1'b1;
          end else begin
            last_idx <= IDX_W'(n_raw - 11'd1);
          end
          if (n_raw == 11'd0) begin
            state       <= DONE;
            clear_int_o <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          m_data  <= rdata;
          m_sel   <= sel;
          m_last  <= sel && (idx == last_idx);
          m_valid <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (idx == last_idx) begin
              if (!sel) begin
                sel   <= 1'b1;
                idx   <= '0;
                state <= READ;
              end else begin
                state       <= DONE;
                clear_int_o <= 1'b1;
              end
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          clear_int_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_dump_reader.sv
// Directed bench for jtag_dump_reader: a bench-side RAM image predicts every streamed beat.
module tb_jtag_dump_reader;

  logic        sclk;
  logic        reset;
  logic        ram_we;
  logic [8:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic        int_i;
  logic [15:0] datalen_i;
  logic        clear_int_o;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sel;
  logic        m_last;
  logic        busy_o;
  logic        overflow_o;

  logic [31:0] exp_mem [512];
  int          checks = 0;
  int          errors = 0;

  jtag_dump_reader dut (
    .sclk        (sclk),
    .reset       (reset),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .int_i       (int_i),
    .datalen_i   (datalen_i),
    .clear_int_o (clear_int_o),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sel       (m_sel),
    .m_last      (m_last),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ram_write(input logic [8:0] addr, input logic [31:0] data);
    @(negedge sclk);
    ram_we    = 1'b1;
    ram_waddr = addr;
    ram_wdata = data;
    exp_mem[addr] = data;
    @(negedge sclk);
    ram_we = 1'b0;
  endtask

  // Two-cycle INT pulse; the sequencer leaves IDLE on the first edge.
  task automatic fire_int(input logic [15:0] dl);
    @(negedge sclk);
    datalen_i = dl;
    int_i     = 1'b1;
    @(negedge sclk);
    @(negedge sclk);
    int_i = 1'b0;
  endtask

  task automatic collect_dump(input int n, input int stall_beat);
    int          t;
    int          sel_e;
    int          idx_e;
    logic [31:0] exp_d;
    logic        exp_last;
    for (int i = 0; i < 2 * n; i++) begin
      sel_e    = (i >= n) ? 1 : 0;
      idx_e    = (sel_e == 1) ? i - n : i;
      exp_d    = exp_mem[(sel_e == 1 ? 128 : 0) + idx_e];
      exp_last = (i == 2 * n - 1);
      t = 0;
      if (i == stall_beat) m_ready = 1'b0;
      while (m_valid !== 1'b1 && t < 20) begin
        @(negedge sclk);
        t++;
      end
      if (t >= 20) begin
        check_output("beat_timeout", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        return;
      end
      check_output("beat_data", m_data, exp_d);
      check_output("beat_sel", {31'd0, m_sel}, sel_e[31:0]);
      check_output("beat_last", {31'd0, m_last}, {31'd0, exp_last});
      if (i == stall_beat) begin
        repeat (5) begin
          @(negedge sclk);
          check_output("stall_valid", {31'd0, m_valid}, 32'd1);
          check_output("stall_data", m_data, exp_d);
          check_output("stall_sel", {31'd0, m_sel}, sel_e[31:0]);
          check_output("stall_last", {31'd0, m_last}, {31'd0, exp_last});
        end
        m_ready = 1'b1;
      end
      @(negedge sclk);
      check_output("valid_drop", {31'd0, m_valid}, 32'd0);
    end
    check_output("clear_pulse", {31'd0, clear_int_o}, 32'd1);
    @(negedge sclk);
    check_output("clear_single", {31'd0, clear_int_o}, 32'd0);
    check_output("busy_idle", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int t;
    int valid_seen;
    reset     = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    int_i     = 1'b0;
    datalen_i = '0;
    m_ready   = 1'b1;
    for (int a = 0; a < 512; a++) exp_mem[a] = 32'hDEAD_BEEF;

    repeat (3) @(negedge sclk);
    check_output("rst_valid", {31'd0, m_valid}, 32'd0);
    check_output("rst_busy", {31'd0, busy_o}, 32'd0);
    check_output("rst_clear", {31'd0, clear_int_o}, 32'd0);
    check_output("rst_overflow", {31'd0, overflow_o}, 32'd0);
    check_output("rst_last", {31'd0, m_last}, 32'd0);
    reset = 1'b1;

    $display("[TB] basic two-word dump");
    ram_write(9'h000, 32'h0000_00A0);
    ram_write(9'h001, 32'h0000_00A1);
    ram_write(9'h080, 32'h0000_00B0);
    ram_write(9'h081, 32'h0000_00B1);
    fire_int(16'h0040);
    collect_dump(2, -1);
    check_output("ovf_after_basic", {31'd0, overflow_o}, 32'd0);

    $display("[TB] filling both regions");
    for (int a = 0; a < 256; a++)
      ram_write(a[8:0], 32'hC000_0000 | (a * 32'h0001_0003));

    $display("[TB] partial-dword lengths");
    fire_int(16'h0025);
    collect_dump(2, -1);
    fire_int(16'h0005);
    collect_dump(1, -1);

    $display("[TB] backpressure");
    fire_int(16'h0060);
    collect_dump(3, 1);

    $display("[TB] zero length");
    fire_int(16'h0000);
    t = 0;
    valid_seen = 0;
    while (clear_int_o !== 1'b1 && t < 20) begin
      if (m_valid === 1'b1) valid_seen = 1;
      @(negedge sclk);
      t++;
    end
    check_output("zero_clear", {31'd0, clear_int_o}, 32'd1);
    check_output("zero_no_beats", valid_seen[31:0] | {31'd0, m_valid}, 32'd0);
    @(negedge sclk);
    check_output("zero_clear_single", {31'd0, clear_int_o}, 32'd0);
    check_output("zero_busy", {31'd0, busy_o}, 32'd0);

    $display("[TB] clamped dump");
    fire_int({1'b0, 10'd200, 5'd0});
    collect_dump(128, -1);
    check_output("ovf_set", {31'd0, overflow_o}, 32'd1);
    fire_int(16'h0040);
    collect_dump(2, -1);
    check_output("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    $display("[TB] reset during send");
    m_ready = 1'b0;
    fire_int(16'h0040);
    t = 0;
    while (m_valid !== 1'b1 && t < 20) begin
      @(negedge sclk);
      t++;
    end
    check_output("pre_reset_valid", {31'd0, m_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check_output("async_valid", {31'd0, m_valid}, 32'd0);
    check_output("async_busy", {31'd0, busy_o}, 32'd0);
    check_output("async_data", m_data, 32'd0);
    check_output("async_overflow", {31'd0, overflow_o}, 32'd0);
    @(negedge sclk);
    reset   = 1'b1;
    m_ready = 1'b1;
    @(negedge sclk);
    check_output("post_reset_idle", {31'd0, busy_o}, 32'd0);
    fire_int(16'h0041);
    collect_dump(3, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
